// File: rtl/pdp8l_iop_pkg.sv
// Shared types and constants for the PDP-8/L IOT pulse arbiter.
// FSM state encoding, status bit positions, IOT opcode base.
package pdp8l_iop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_START   = 3'd2,
        ST_COLLECT = 3'd3,
        ST_HOLD    = 3'd4,
        ST_STOP    = 3'd5,
        ST_GAP     = 3'd6
    } iop_state_t;

    localparam int STAT_CONFLICT = 31;
    localparam int STAT_TIMEOUT  = 30;
    localparam int STAT_CNT_LSB  = 8;
    localparam int STAT_SLOT_LSB = 4;

    localparam logic [11:0] IOT_BASE = 12'o6000;

endpackage

// File: rtl/pdp8l_iop_merge.sv
// Combinational merge of per-slot device returns.
// Ports: i_data/i_acclr/i_ioskip/i_intrq per slot in;
//        o_data/o_acclr/o_ioskip/o_intany/o_conflict merged out;
//        o_intslot (PDP8L_IOP_INTPRIO_EN only) lowest requesting slot.
module pdp8l_iop_merge
    import pdp8l_iop_pkg::*;
#(
    parameter int NDEV = 4
) (
    input  logic [12*NDEV-1:0] i_data,
    input  logic [NDEV-1:0]    i_acclr,
    input  logic [NDEV-1:0]    i_ioskip,
    input  logic [NDEV-1:0]    i_intrq,
    output logic [11:0]        o_data,
    output logic               o_acclr,
    output logic               o_ioskip,
    output logic               o_intany,
    output logic               o_conflict
`ifdef PDP8L_IOP_INTPRIO_EN
    ,
    output logic [3:0]         o_intslot
`endif
);

    logic w_one;
    logic w_many;

    // w_one/w_many form a saturating "how many slots drive data" count.
    always_comb begin
        o_data = '0;
        w_one  = 1'b0;
        w_many = 1'b0;
        for (int k = 0; k < NDEV; k++) begin
            o_data = o_data | i_data[12*k +: 12];
            if (|i_data[12*k +: 12]) begin
                w_many = w_many | w_one;
                w_one  = 1'b1;
            end
        end
    end

    assign o_acclr    = |i_acclr;
    assign o_ioskip   = |i_ioskip;
    assign o_intany   = |i_intrq;
    assign o_conflict = w_many;

`ifdef PDP8L_IOP_INTPRIO_EN
    // Scan high to low so the lowest-numbered slot wins.
    always_comb begin
        o_intslot = 4'hF;
        for (int k = NDEV - 1; k >= 0; k--) begin
            if (i_intrq[k]) o_intslot = 4'(k);
        end
    end
`endif

endmodule

// File: rtl/pdp8l_iop_arbiter.sv
// Sequences each IOT into one iopstart/iopstop pair, merges device returns.
// Ports: CLOCK/RESET/BINIT, CPU IOT in, iopstart/iopstop/ioopcode out,
//        per-slot dev_* in, merged CPU return out, status/status_clr.
// Optional: PDP8L_IOP_INTPRIO_EN adds intslot and status[7:4].
module pdp8l_iop_arbiter
    import pdp8l_iop_pkg::*;
#(
    parameter int NDEV    = 4,
    parameter int SETTLE  = 3,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               BINIT,
    input  logic               iot_active,
    input  logic [11:0]        ioopcode_in,
    output logic               iopstart,
    output logic               iopstop,
    output logic [11:0]        ioopcode,
    input  logic [12*NDEV-1:0] dev_devtocpu,
    input  logic [NDEV-1:0]    dev_acclr,
    input  logic [NDEV-1:0]    dev_ioskip,
    input  logic [NDEV-1:0]    dev_intrq,
    output logic [11:0]        devtocpu,
    output logic               AC_CLEAR,
    output logic               IO_SKIP,
    output logic               INT_RQST,
`ifdef PDP8L_IOP_INTPRIO_EN
    output logic [3:0]         intslot,
`endif
    output logic [31:0]        status,
    input  logic               status_clr
);

    iop_state_t  r_state;
    iop_state_t  w_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nx;
    logic [11:0] r_hcnt;
    logic [11:0] w_hcnt_nx;
    logic [11:0] r_prev;
    logic [11:0] r_op;
    logic [11:0] r_data;
    logic        r_ac;
    logic        r_sk;
    logic        r_int;
    logic        r_conf;
    logic        r_tmo;
    logic [7:0]  r_ccnt;
    logic        w_latch;
    logic        w_capture;
    logic        w_clear;
    logic        w_tmo;
    logic [11:0] w_data;
    logic        w_acclr;
    logic        w_ioskip;
    logic        w_intany;
    logic        w_conflict;
    logic [3:0]  w_slot_bits;

`ifdef PDP8L_IOP_INTPRIO_EN
    logic [3:0]  w_intslot;
    logic [3:0]  r_slot;
`endif

    pdp8l_iop_merge #(.NDEV(NDEV)) u_merge (
        .i_data     (dev_devtocpu),
        .i_acclr    (dev_acclr),
        .i_ioskip   (dev_ioskip),
        .i_intrq    (dev_intrq),
        .o_data     (w_data),
        .o_acclr    (w_acclr),
        .o_ioskip   (w_ioskip),
        .o_intany   (w_intany),
        .o_conflict (w_conflict)
`ifdef PDP8L_IOP_INTPRIO_EN
        ,
        .o_intslot  (w_intslot)
`endif
    );

    always_comb begin
        w_next    = r_state;
        w_cnt_nx  = r_cnt;
        w_hcnt_nx = r_hcnt;
        w_latch   = 1'b0;
        w_capture = 1'b0;
        w_clear   = 1'b0;
        w_tmo     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (iot_active) begin
                    w_next   = ST_SETTLE;
                    w_cnt_nx = '0;
                end
            end
            ST_SETTLE: begin
                // r_prev holds last cycle's opcode; any change restarts.
                if (!iot_active) begin
                    w_next = ST_IDLE;
                end else if (ioopcode_in != r_prev) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == 8'(SETTLE - 1)) begin
                    w_next  = ST_START;
                    w_latch = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            ST_START: begin
                w_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                w_next    = ST_HOLD;
                w_capture = 1'b1;
                w_hcnt_nx = 12'd1;
            end
            ST_HOLD: begin
                // Returns drop on the edge that raises iopstop.
                if (!iot_active) begin
                    w_next  = ST_STOP;
                    w_clear = 1'b1;
                end else if (r_hcnt == 12'(TIMEOUT)) begin
                    w_next  = ST_STOP;
                    w_clear = 1'b1;
                    w_tmo   = 1'b1;
                end else begin
                    w_hcnt_nx = r_hcnt + 12'd1;
                end
            end
            ST_STOP: begin
                w_next   = ST_GAP;
                w_cnt_nx = '0;
            end
            ST_GAP: begin
                if (r_cnt == 8'(GAP - 1)) begin
                    w_next   = iot_active ? ST_SETTLE : ST_IDLE;
                    w_cnt_nx = '0;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET || BINIT) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hcnt  <= '0;
            r_prev  <= '0;
            r_op    <= '0;
            r_data  <= '0;
            r_ac    <= 1'b0;
            r_sk    <= 1'b0;
            r_int   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nx;
            r_hcnt  <= w_hcnt_nx;
            r_prev  <= ioopcode_in;
            r_int   <= w_intany;
            if (w_latch) r_op <= ioopcode_in;
            if (w_capture) begin
                r_data <= w_data;
                r_ac   <= w_acclr;
                r_sk   <= w_ioskip;
            end else if (w_clear) begin
                r_data <= '0;
                r_ac   <= 1'b0;
                r_sk   <= 1'b0;
            end
        end
    end

    // Status survives BINIT; a same-cycle event beats status_clr.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_conf <= 1'b0;
            r_tmo  <= 1'b0;
            r_ccnt <= '0;
        end else begin
            if (status_clr) begin
                r_conf <= 1'b0;
                r_tmo  <= 1'b0;
                r_ccnt <= '0;
            end
            if (w_capture && w_conflict && !BINIT) begin
                r_conf <= 1'b1;
                if (status_clr)          r_ccnt <= 8'd1;
                else if (r_ccnt != 8'hFF) r_ccnt <= r_ccnt + 8'd1;
            end
            if (w_tmo && !BINIT) r_tmo <= 1'b1;
        end
    end

`ifdef PDP8L_IOP_INTPRIO_EN
    always_ff @(posedge CLOCK) begin
        if (RESET || BINIT) r_slot <= 4'hF;
        else                r_slot <= w_intslot;
    end
    assign intslot     = r_slot;
    assign w_slot_bits = r_slot;
`else
    assign w_slot_bits = 4'h0;
`endif

    assign iopstart = (r_state == ST_START);
    assign iopstop  = (r_state == ST_STOP);
    assign ioopcode = r_op;
    assign devtocpu = r_data;
    assign AC_CLEAR = r_ac;
    assign IO_SKIP  = r_sk;
    assign INT_RQST = r_int;
    assign status   = {r_conf, r_tmo, 14'b0, r_ccnt,
                       w_slot_bits, 1'b0, r_state};

endmodule

// File: tb/tb_pdp8l_iop_arbiter.sv
// Scoreboard bench for pdp8l_iop_arbiter: transaction-level timing model.
// Build with PDP8L_IOP_INTPRIO_EN to also cover intslot.
module tb_pdp8l_iop_arbiter;

    localparam int ST  = 3;
    localparam int GP  = 2;
    localparam int TMO = 4095;

    typedef struct {
        int          start;
        int          stop;
        logic [11:0] op;
        logic [11:0] data;
        logic        ac;
        logic        sk;
        logic        conf;
        logic        tmo;
    } exp_t;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        BINIT = 1'b0;
    logic        iot_active = 1'b0;
    logic [11:0] ioopcode_in = '0;
    logic [47:0] dev_devtocpu = '0;
    logic [3:0]  dev_acclr = '0;
    logic [3:0]  dev_ioskip = '0;
    logic [3:0]  dev_intrq = '0;
    logic        status_clr = 1'b0;
    logic        iopstart;
    logic        iopstop;
    logic [11:0] ioopcode;
    logic [11:0] devtocpu;
    logic        AC_CLEAR;
    logic        IO_SKIP;
    logic        INT_RQST;
    logic [31:0] status;
`ifdef PDP8L_IOP_INTPRIO_EN
    logic [3:0]  intslot;
`endif

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_stop = -100;

    pdp8l_iop_arbiter dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .BINIT        (BINIT),
        .iot_active   (iot_active),
        .ioopcode_in  (ioopcode_in),
        .iopstart     (iopstart),
        .iopstop      (iopstop),
        .ioopcode     (ioopcode),
        .dev_devtocpu (dev_devtocpu),
        .dev_acclr    (dev_acclr),
        .dev_ioskip   (dev_ioskip),
        .dev_intrq    (dev_intrq),
        .devtocpu     (devtocpu),
        .AC_CLEAR     (AC_CLEAR),
        .IO_SKIP      (IO_SKIP),
        .INT_RQST     (INT_RQST),
`ifdef PDP8L_IOP_INTPRIO_EN
        .intslot      (intslot),
`endif
        .status       (status),
        .status_clr   (status_clr)
    );

    initial forever #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, a, e);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [3:0] lowest(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return 4'(k);
        return 4'hF;
    endfunction

    // Monitor: samples just after each rising edge.
    logic        m_conf = 1'b0;
    logic        m_tmo = 1'b0;
    logic [7:0]  m_cnt = '0;
    exp_t        c;
    bit          have;
    bit          win;
    logic        eint;
    logic [3:0]  eslot;

    initial forever begin
        @(posedge CLOCK);
        #1;
        if (RESET || BINIT) q.delete();
        have = (q.size() > 0);
        if (have) c = q[0];
        if (RESET) begin
            m_conf = 1'b0;
            m_tmo  = 1'b0;
            m_cnt  = '0;
        end else begin
            if (status_clr) begin
                m_conf = 1'b0;
                m_tmo  = 1'b0;
                m_cnt  = '0;
            end
            if (have && cyc == c.start + 2 && c.conf) begin
                m_conf = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
            if (have && cyc == c.stop && c.tmo) m_tmo = 1'b1;
        end
        win = have && cyc >= c.start + 2 && cyc < c.stop;
        chk("iopstart", 32'(iopstart), 32'(have && cyc == c.start));
        chk("iopstop", 32'(iopstop), 32'(have && cyc == c.stop));
        chk("devtocpu", 32'(devtocpu), win ? 32'(c.data) : 32'd0);
        chk("ac_clear", 32'(AC_CLEAR), win ? 32'(c.ac) : 32'd0);
        chk("io_skip", 32'(IO_SKIP), win ? 32'(c.sk) : 32'd0);
        if (have && cyc >= c.start && cyc <= c.stop)
            chk("ioopcode", 32'(ioopcode), 32'(c.op));
        if (have && cyc == c.start) chk("st_start", 32'(status[2:0]), 32'd2);
        if (have && cyc == c.stop) chk("st_stop", 32'(status[2:0]), 32'd5);
        if (RESET) begin
            chk("rst_op", 32'(ioopcode), 32'd0);
            chk("rst_state", 32'(status[2:0]), 32'd0);
        end
        chk("conflict", 32'(status[31]), 32'(m_conf));
        chk("timeout", 32'(status[30]), 32'(m_tmo));
        chk("ccount", 32'(status[15:8]), 32'(m_cnt));
        eint  = (RESET || BINIT) ? 1'b0 : |dev_intrq;
        eslot = (RESET || BINIT) ? 4'hF : lowest(dev_intrq);
        chk("int_rqst", 32'(INT_RQST), 32'(eint));
`ifdef PDP8L_IOP_INTPRIO_EN
        chk("intslot", 32'(intslot), 32'(eslot));
        chk("st_slot", 32'(status[7:4]), 32'(eslot));
`else
        chk("st_slot", 32'(status[7:4]), 32'd0);
`endif
        if (have && cyc >= c.stop) void'(q.pop_front());
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLOCK);
            dev_intrq = 4'($urandom);
        end
    endtask

    // One IOT. Called at a falling edge; all timing derives from the
    // entry cycle, the last opcode change and the drop cycle.
    task automatic iot(input logic [11:0] op, input int chg,
                       input logic [11:0] op2, input logic [47:0] dd,
                       input logic [3:0] ac, input logic [3:0] sk,
                       input int hold, input bit stuck, input int clr_at);
        exp_t        r;
        exp_t        r2;
        int          c0, e, t, d, endc, nz;
        logic [11:0] orv;
        c0 = cyc;
        iot_active   = 1'b1;
        ioopcode_in  = op;
        dev_devtocpu = dd;
        dev_acclr    = ac;
        dev_ioskip   = sk;
        e = imax(c0, last_stop + GP);
        t = e + chg;
        orv = '0;
        nz = 0;
        for (int k = 0; k < 4; k++) begin
            orv = orv | dd[12*k +: 12];
            if (dd[12*k +: 12] != 12'd0) nz++;
        end
        r.start = ((chg > 0) ? t : e) + ST + 1;
        r.op    = (chg > 0) ? op2 : op;
        r.data  = orv;
        r.ac    = |ac;
        r.sk    = |sk;
        r.conf  = (nz > 1);
        if (stuck) begin
            r.stop   = r.start + 2 + TMO;
            r.tmo    = 1'b1;
            r2       = r;
            r2.tmo   = 1'b0;
            r2.start = r.stop + GP + ST + 1;
            d        = r2.start + hold;
            r2.stop  = imax(d, r2.start + 2) + 1;
            q.push_back(r);
            q.push_back(r2);
            last_stop = r2.stop;
        end else begin
            r.tmo  = 1'b0;
            d      = r.start + hold;
            r.stop = imax(d, r.start + 2) + 1;
            q.push_back(r);
            last_stop = r.stop;
        end
        endc = last_stop + 1;
        while (cyc < endc) begin
            @(negedge CLOCK);
            dev_intrq = 4'($urandom);
            if (chg > 0 && cyc == t) ioopcode_in = op2;
            if (cyc == d) iot_active = 1'b0;
            status_clr = (clr_at >= 0 && cyc == r.start + clr_at);
        end
        status_clr   = 1'b0;
        dev_devtocpu = '0;
        dev_acclr    = '0;
        dev_ioskip   = '0;
    endtask

    task automatic rst_in_hold();
        exp_t r;
        iot_active  = 1'b1;
        ioopcode_in = 12'o6050;
        dev_acclr   = 4'b0100;
        r.start = imax(cyc, last_stop + GP) + ST + 1;
        r.stop  = r.start + 1000;
        r.op    = 12'o6050;
        r.data  = '0;
        r.ac    = 1'b1;
        r.sk    = 1'b0;
        r.conf  = 1'b0;
        r.tmo   = 1'b0;
        q.push_back(r);
        while (cyc < r.start + 5) begin
            @(negedge CLOCK);
            dev_intrq = 4'($urandom);
        end
        RESET      = 1'b1;
        iot_active = 1'b0;
        @(negedge CLOCK);
        RESET     = 1'b0;
        dev_acclr = '0;
        last_stop = -100;
    endtask

    function automatic logic [11:0] rslot();
        return ($urandom_range(0, 2) == 0) ? 12'($urandom_range(1, 4095))
                                           : 12'd0;
    endfunction

    logic [47:0] dd;

    initial begin
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        idle(2);

        iot(12'o6031, 0, 12'o0, 48'h0, 4'b0, 4'b0010, 6, 1'b0, -1);
        idle(3);

        dd = '0;
        dd[11:0]  = 12'o0101;
        dd[35:24] = 12'o0040;
        iot(12'o6041, 0, 12'o0, dd, 4'b0, 4'b0, 4, 1'b0, -1);
        idle(2);
        status_clr = 1'b1;
        idle(1);
        status_clr = 1'b0;
        idle(2);

        iot(12'o6031, 2, 12'o6036, 48'h0, 4'b0, 4'b0, 3, 1'b0, -1);
        idle(2);

        iot(12'o6041, 0, 12'o0, dd, 4'b0001, 4'b0, 2, 1'b0, -1);
        iot(12'o6042, 0, 12'o0, dd, 4'b0, 4'b0, 0, 1'b0, -1);
        iot(12'o6043, 0, 12'o0, dd, 4'b0, 4'b0, 5, 1'b0, 1);
        idle(4);

        iot_active  = 1'b1;
        ioopcode_in = 12'o6046;
        idle(2);
        iot_active = 1'b0;
        idle(8);

        BINIT = 1'b1;
        idle(1);
        BINIT = 1'b0;
        idle(2);

        for (int i = 0; i < 40; i++) begin
            dd = {rslot(), rslot(), rslot(), rslot()};
            iot(12'o6000 | 12'($urandom_range(0, 511)),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, ST) : 0,
                12'o6000 | 12'($urandom_range(0, 511)),
                dd,
                4'($urandom) & 4'($urandom),
                4'($urandom) & 4'($urandom),
                $urandom_range(0, 8), 1'b0,
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1);
            idle($urandom_range(0, 3));
        end

        iot(12'o6032, 0, 12'o0, 48'h0, 4'b0, 4'b1000, 3, 1'b1, -1);
        idle(3);

        rst_in_hold();
        idle(5);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
